// File: rtl/shift_pipe_if.sv
// rtl/shift_pipe_if.sv - command and result handshake bundle for shift_pipe
interface shift_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_movement;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [1:0]       out_op;

  modport master (
    output in_valid, in_a, in_movement, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_op
  );

  modport slave (
    input  in_valid, in_a, in_movement, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_op
  );
endinterface

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - two-stage SRL/SLL/SRA/ROR unit built around a logical-right shifter
// Optional overshift handling (|movement[31:5]) is enabled by SHIFT_PIPE_OVERSHIFT_EN.
module srl #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic [WIDTH-1:0]      i_data,
  input  logic [SHAMT_BITS-1:0] i_shamt,
  output logic [WIDTH-1:0]      o_data
);
  logic [WIDTH-1:0] w_stage [SHAMT_BITS+1];

  assign w_stage[0] = i_data;

  for (genvar s = 0; s < SHAMT_BITS; s++) begin : g_stage
    assign w_stage[s+1] = i_shamt[s] ? (w_stage[s] >> (1 << s)) : w_stage[s];
  end

  assign o_data = w_stage[SHAMT_BITS];
endmodule

module shift_pipe #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  shift_pipe_if.slave  bus
);
  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  function automatic logic [WIDTH-1:0] f_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] rev;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = v[WIDTH-1-i];
    end
    return rev;
  endfunction

  logic                  r_s1_valid;
  op_e                   r_s1_op;
  logic [SHAMT_BITS-1:0] r_s1_n;
  logic [WIDTH-1:0]      r_s1_pre;
  logic                  r_s1_sign;
`ifdef SHIFT_PIPE_OVERSHIFT_EN
  logic                  r_s1_ovf;
`else
  logic                  w_unused_movement_hi;
`endif

  logic                  r_s2_valid;
  logic [WIDTH-1:0]      r_s2_result;
  logic                  r_s2_zero;
  op_e                   r_s2_op;

  logic                  w_s2_free;
  logic                  w_s1_adv;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic [WIDTH-1:0]      w_r;
  logic [WIDTH-1:0]      w_mask;
  logic [SHAMT_BITS-1:0] w_wrap_n;
  logic [WIDTH-1:0]      w_wrap_src;
  logic [WIDTH-1:0]      w_wrap_raw;
  logic [WIDTH-1:0]      w_wrap;
  logic [WIDTH-1:0]      w_result;

  assign w_s2_free  = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign w_in_ready = !rst && (!r_s1_valid || w_s2_free);
  assign w_in_fire  = bus.in_valid && w_in_ready;

`ifndef SHIFT_PIPE_OVERSHIFT_EN
  assign w_unused_movement_hi = ^bus.in_movement[WIDTH-1:SHAMT_BITS];
`endif

  // SLL is pre-reversed here so the single right shifter serves every op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_SRL;
      r_s1_n     <= '0;
      r_s1_pre   <= '0;
      r_s1_sign  <= 1'b0;
`ifdef SHIFT_PIPE_OVERSHIFT_EN
      r_s1_ovf   <= 1'b0;
`endif
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= op_e'(bus.in_op);
      r_s1_n     <= bus.in_movement[SHAMT_BITS-1:0];
      r_s1_pre   <= (op_e'(bus.in_op) == OP_SLL) ? f_reverse(bus.in_a) : bus.in_a;
      r_s1_sign  <= bus.in_a[WIDTH-1];
`ifdef SHIFT_PIPE_OVERSHIFT_EN
      r_s1_ovf   <= |bus.in_movement[WIDTH-1:SHAMT_BITS];
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  srl #(.WIDTH(WIDTH), .SHAMT_BITS(SHAMT_BITS)) u_srl_data (
    .i_data  (r_s1_pre),
    .i_shamt (r_s1_n),
    .o_data  (w_r)
  );

  srl #(.WIDTH(WIDTH), .SHAMT_BITS(SHAMT_BITS)) u_srl_mask (
    .i_data  ({WIDTH{1'b1}}),
    .i_shamt (r_s1_n),
    .o_data  (w_mask)
  );

  // Two's complement of n is (32 - n) mod 32; the n == 0 case is forced to no wrap.
  assign w_wrap_n   = -r_s1_n;
  assign w_wrap_src = f_reverse(r_s1_pre);

  srl #(.WIDTH(WIDTH), .SHAMT_BITS(SHAMT_BITS)) u_srl_wrap (
    .i_data  (w_wrap_src),
    .i_shamt (w_wrap_n),
    .o_data  (w_wrap_raw)
  );

  assign w_wrap = (r_s1_n == '0) ? '0 : f_reverse(w_wrap_raw);

  always_comb begin
    w_result = w_r;
    case (r_s1_op)
      OP_SRL:  w_result = w_r;
      OP_SLL:  w_result = f_reverse(w_r);
      OP_SRA:  w_result = w_r | (r_s1_sign ? ~w_mask : '0);
      OP_ROR:  w_result = w_r | w_wrap;
      default: w_result = w_r;
    endcase
`ifdef SHIFT_PIPE_OVERSHIFT_EN
    if (r_s1_ovf) begin
      case (r_s1_op)
        OP_SRL:  w_result = '0;
        OP_SLL:  w_result = '0;
        OP_SRA:  w_result = {WIDTH{r_s1_sign}};
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_zero   <= 1'b0;
      r_s2_op     <= OP_SRL;
    end else if (w_s1_adv) begin
      r_s2_valid  <= 1'b1;
      r_s2_result <= w_result;
      r_s2_zero   <= (w_result == '0);
      r_s2_op     <= r_s1_op;
    end else if (w_s2_free) begin
      r_s2_valid  <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_result = r_s2_result;
  assign bus.out_zero   = r_s2_zero;
  assign bus.out_op     = r_s2_op;
endmodule
